// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter slice.
//   - Op encodings for the shift core (also used by ALU shifters).
//   - Result-register FSM state encoding.
package shift_arbiter_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // IDLE: result register empty; FULL: holds an undelivered result.
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/shift_arbiter_core.sv
// Purely combinational logarithmic barrel shifter.
// Ports:
//   a      in  DATA_W   operand
//   shamt  in  SHAMT_W  shift amount (0..DATA_W-1, no extra wrap)
//   op     in  2        OP_SLL / OP_SRL / OP_SRA / OP_RSVD
//   result out DATA_W   shifted operand; zero for OP_RSVD
// SLL and SRL fill with zeros, SRA fills with a[DATA_W-1].
module shift_core
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [DATA_W-1:0]  result
);

    logic              shift_left;
    logic              fill_bit;
    logic [DATA_W-1:0] stage [SHAMT_W+1];

    assign shift_left = (op == OP_SLL);
    // Only SRA shifts in copies of the sign bit; every other right shift zero-fills.
    assign fill_bit   = (op == OP_SRA) ? a[DATA_W-1] : 1'b0;
    assign stage[0]   = a;

    // Stage i shifts by 2**i when shamt[i] is set, so SHAMT_W stages cover 0..DATA_W-1.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int K = 1 << i;
        logic [DATA_W-1:0] shl;
        logic [DATA_W-1:0] shr;
        assign shl          = {stage[i][DATA_W-1-K:0], {K{1'b0}}};
        assign shr          = {{K{fill_bit}}, stage[i][DATA_W-1:K]};
        assign stage[i+1]   = shamt[i] ? (shift_left ? shl : shr) : stage[i];
    end

    assign result = (op == OP_RSVD) ? '0 : stage[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters,
// with a single registered result stage.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid/ready           requester N handshake (N = 0, 1)
//   reqN_op/a/shamt/tag        requester N operation fields
//   resp_valid/ready           result handshake
//   resp_data/src/tag/err      result, winning requester, its tag, reserved-op flag
//   state_dbg                  current result-register FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Requesters hold valid and fields stable until ready. Readies depend only
// on the valids, the FSM state, rr_ptr and resp_ready -- never on data fields.
// The result stage holds resp_* stable while resp_valid=1 and resp_ready=0.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_data,
    output logic               resp_src,
    output logic [TAG_W-1:0]   resp_tag,
    output logic               resp_err,
    output state_t             state_dbg
);

    state_t             state;
    logic               rr_ptr;
    logic               can_accept;
    logic               any_valid;
    logic               both_valid;
    logic               gsel;
    logic               grant;
    logic [1:0]         sel_op;
    logic [DATA_W-1:0]  sel_a;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [TAG_W-1:0]   sel_tag;
    logic [DATA_W-1:0]  core_result;

    // Draining and refilling in the same cycle keeps throughput at one op per cycle.
    assign can_accept = (state == IDLE) | (resp_valid & resp_ready);
    assign any_valid  = req0_valid | req1_valid;
    assign both_valid = req0_valid & req1_valid;
    // Contested: rr_ptr picks. Uncontested: whichever is valid (req1_valid is 0 when only req0).
    assign gsel       = both_valid ? rr_ptr : req1_valid;
    assign grant      = can_accept & any_valid;
    assign req0_ready = grant & ~gsel;
    assign req1_ready = grant & gsel;

    assign sel_op    = gsel ? req1_op    : req0_op;
    assign sel_a     = gsel ? req1_a     : req0_a;
    assign sel_shamt = gsel ? req1_shamt : req0_shamt;
    assign sel_tag   = gsel ? req1_tag   : req0_tag;

    shift_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .a      (sel_a),
        .shamt  (sel_shamt),
        .op     (sel_op),
        .result (core_result)
    );

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_src   <= 1'b0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (resp_ready && !grant) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (grant) begin
                resp_valid <= 1'b1;
                resp_data  <= core_result;
                resp_src   <= gsel;
                resp_tag   <= sel_tag;
                resp_err   <= (sel_op == OP_RSVD);
                // The loser of a contested grant is favoured next time.
                if (both_valid) begin
                    rr_ptr <= ~gsel;
                end
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: expected responses are queued when a
// request handshake is seen and checked in order by a response monitor.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;
    localparam int TAG_W   = 4;
    localparam int EW      = 2 + TAG_W + DATA_W;   // {err, src, tag, data}

    logic               clk;
    logic               rst;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [1:0]         req0_op, req1_op;
    logic [DATA_W-1:0]  req0_a, req1_a;
    logic [SHAMT_W-1:0] req0_shamt, req1_shamt;
    logic [TAG_W-1:0]   req0_tag, req1_tag;
    logic               resp_valid;
    logic               resp_ready;
    logic [DATA_W-1:0]  resp_data;
    logic               resp_src;
    logic [TAG_W-1:0]   resp_tag;
    logic               resp_err;
    state_t             state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] exp0_data, exp1_data;

    shift_arbiter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_tag   (req1_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [1:0] op, input logic [DATA_W-1:0] a,
                          input logic [SHAMT_W-1:0] sh, input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] exp);
        req0_valid = v; req0_op = op; req0_a = a; req0_shamt = sh; req0_tag = tag;
        exp0_data  = exp;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [DATA_W-1:0] a,
                          input logic [SHAMT_W-1:0] sh, input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] exp);
        req1_valid = v; req1_op = op; req1_a = a; req1_shamt = sh; req1_tag = tag;
        exp1_data  = exp;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", EW'(exp_q.size()), '0);
    endtask

    // ---------------- scoreboard push on accepted requests ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready)
                exp_q.push_back({req0_op == 2'b11, 1'b0, req0_tag, exp0_data});
            if (req1_valid && req1_ready)
                exp_q.push_back({req1_op == 2'b11, 1'b1, req1_tag, exp1_data});
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected actual=%0h required=none",
                         {resp_err, resp_src, resp_tag, resp_data});
            end else begin
                check("resp", {resp_err, resp_src, resp_tag, resp_data}, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [1:0]        t_op [5];
    logic [DATA_W-1:0] t_a  [5];
    logic [5:0]        t_sh [5];
    logic [DATA_W-1:0] t_ex [5];

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        drive0(1'b0, OP_SLL, '0, '0, '0, '0);
        drive1(1'b0, OP_SLL, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_resp", {resp_err, resp_src, resp_tag, resp_data}, '0);
        check("reset_valid", EW'(resp_valid), '0);
        check("reset_state", EW'(state_dbg), EW'(IDLE));
        tick();
        rst = 1'b0;

        // 1) single requester, SLL by 63
        resp_ready = 1'b1;
        drive0(1'b1, OP_SLL, 64'h1, 6'd63, 4'h1, 64'h8000_0000_0000_0000);
        @(negedge clk);
        check("t1_ready", EW'({req1_ready, req0_ready}), EW'(2'b01));
        tick();
        drive0(1'b0, OP_SLL, '0, '0, '0, '0);
        @(negedge clk);
        check("t1_valid", EW'(resp_valid), EW'(1'b1));
        drain();

        // 2) contested every cycle: grants alternate 0,1,0,1
        tick();
        drive0(1'b1, OP_SRL, 64'hF000_0000_0000_0000, 6'd4, 4'h2, 64'h0F00_0000_0000_0000);
        drive1(1'b1, OP_SRA, 64'hF000_0000_0000_0000, 6'd4, 4'h3, 64'hFF00_0000_0000_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_grant", EW'({req1_ready, req0_ready}), (i % 2 == 0) ? EW'(2'b01) : EW'(2'b10));
            tick();
        end
        drive0(1'b0, OP_SLL, '0, '0, '0, '0);
        drive1(1'b0, OP_SLL, '0, '0, '0, '0);
        drain();

        // 3) back-pressure for 3 cycles while both requesters wait
        tick();
        resp_ready = 1'b0;
        drive0(1'b1, OP_SLL, 64'h3, 6'd1, 4'h4, 64'h6);
        drive1(1'b1, OP_SRL, 64'h10, 6'd4, 4'h6, 64'h1);
        @(negedge clk);
        check("t3_first", EW'({req1_ready, req0_ready}), EW'(2'b01));
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", EW'({req1_ready, req0_ready}), '0);
            check("t3_stall_resp", {resp_err, resp_src, resp_tag, resp_data}, {1'b0, 1'b0, 4'h4, 64'h6});
            check("t3_stall_state", EW'({resp_valid, state_dbg}), EW'({1'b1, FULL}));
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("t3_release", EW'({req1_ready, req0_ready}), EW'(2'b10));
        tick();
        drive0(1'b0, OP_SLL, '0, '0, '0, '0);
        drive1(1'b0, OP_SLL, '0, '0, '0, '0);
        drain();

        // 4) reserved op from requester 1
        tick();
        drive1(1'b1, OP_RSVD, 64'hDEAD, 6'd3, 4'h5, 64'h0);
        @(negedge clk);
        check("t4_ready", EW'({req1_ready, req0_ready}), EW'(2'b10));
        tick();
        drive1(1'b0, OP_SLL, '0, '0, '0, '0);
        drain();

        // 5) shamt=0 identity for all ops, plus shamt=63 right shifts
        t_op[0] = OP_SLL; t_sh[0] = 6'd0;  t_ex[0] = 64'h8000_0000_0000_0001;
        t_op[1] = OP_SRL; t_sh[1] = 6'd0;  t_ex[1] = 64'h8000_0000_0000_0001;
        t_op[2] = OP_SRA; t_sh[2] = 6'd0;  t_ex[2] = 64'h8000_0000_0000_0001;
        t_op[3] = OP_SRA; t_sh[3] = 6'd63; t_ex[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        t_op[4] = OP_SRL; t_sh[4] = 6'd63; t_ex[4] = 64'h1;
        for (int i = 0; i < 5; i++) t_a[i] = 64'h8000_0000_0000_0001;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, t_op[i], t_a[i], t_sh[i], 4'(i + 8), t_ex[i]);
            @(negedge clk);
            check("t5_ready", EW'(req0_ready), EW'(1'b1));
            tick();
        end
        drive0(1'b0, OP_SLL, '0, '0, '0, '0);
        drain();

        // 6) reset while FULL with rr_ptr=1 (contested grant to req0 then stall)
        tick();
        resp_ready = 1'b0;
        drive0(1'b1, OP_SLL, 64'h1, 6'd1, 4'hA, 64'h2);
        drive1(1'b1, OP_SLL, 64'h1, 6'd2, 4'hB, 64'h4);
        @(negedge clk);
        check("t6_grant0", EW'({req1_ready, req0_ready}), EW'(2'b01));
        tick();
        drive0(1'b0, OP_SLL, '0, '0, '0, '0);
        drive1(1'b0, OP_SLL, '0, '0, '0, '0);
        @(negedge clk);
        check("t6_full", EW'(state_dbg), EW'(FULL));
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_after_rst", EW'({resp_valid, state_dbg}), EW'({1'b0, IDLE}));
        tick();
        resp_ready = 1'b1;
        drive0(1'b1, OP_SRL, 64'h80, 6'd7, 4'hC, 64'h1);
        drive1(1'b1, OP_SRL, 64'h80, 6'd3, 4'hD, 64'h10);
        @(negedge clk);
        check("t6_ptr_reset", EW'({req1_ready, req0_ready}), EW'(2'b01));
        tick();
        drive0(1'b0, OP_SLL, '0, '0, '0, '0);
        drive1(1'b0, OP_SLL, '0, '0, '0, '0);
        drain();

        repeat (2) @(negedge clk);
        check("final_queue_empty", EW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
